a0_trace_fifo: RTL
==================

// Module: a0_trace_fifo
// PURPOSE
//  Sits directly downstream of the pipelined CPU top and consumes its a0 test output.
//  Records every change of a0, timestamped with a free-running cycle counter, into a FIFO.
//  The FIFO drains over a valid/ready stream to the display/bench side.
//  Detects and flags entries lost to overflow, so short a0 transients are never silently missed.
// PARAMETERS
//  DATA_WIDTH  32  width of a0 and of out_data
//  DEPTH       16  FIFO entries; power of 2, >= 2
//  TS_WIDTH    16  timestamp counter width
// PORTS
//  clk          in   1                  clock; all state updates on rising edge
//  rst          in   1                  asynchronous reset, active-low (0 = reset)
//  a0_in        in   DATA_WIDTH         a0 output of CPU top
//  capture_en   in   1                  1 = changes are recorded
//  clear        in   1                  synchronous flush of FIFO and loss flags
//  out_valid    out  1                  head entry available
//  out_ready    in   1                  consumer accepts head entry this cycle
//  out_data     out  DATA_WIDTH         head entry a0 value
//  out_ts       out  TS_WIDTH           head entry timestamp
//  out_lost     out  1                  >=1 change was dropped immediately before this entry
//  count        out  $clog2(DEPTH)+1    entries currently held, 0..DEPTH
//  overflow     out  1                  sticky: a drop has occurred since reset/clear
//  drop_cnt     out  8                  dropped changes, saturates at 255
// BEHAVIOUR
//  Reset (rst=0, async): FIFO empty, rd/wr ptrs=0, count=0, out_valid=0, out_data/out_ts/out_lost=0,
//    overflow=0, drop_cnt=0, lost_pending=0, ts counter=0, a0_prev=0.
//  ts counter: +1 every cycle from reset release, wraps 2^TS_WIDTH-1 -> 0; unaffected by clear.
//  a0_prev <= a0_in every cycle, regardless of capture_en/clear.
//  change = capture_en && (a0_in != a0_prev).
//    A nonzero a0 in the first post-reset cycle counts as a change.
//  push = change && (count<DEPTH || pop); pop = out_valid && out_ready.
//  Pushed entry = {a0_in, ts value in detection cycle, lost_pending}; lost_pending then cleared.
//  drop = change && !push:
//    lost_pending<=1; overflow<=1; drop_cnt+=1 (saturating at 255). Stored data untouched.
//  Full FIFO with simultaneous pop and change: both occur, count stays DEPTH, no drop.
//  Empty FIFO: pop impossible (out_valid=0). out_ready is ignored when out_valid=0.
//  Output is first-word-fall-through, driven from registered storage.
//    A change detected at edge n: out_valid=1 after edge n+1 (1-cycle latency) when the FIFO was empty.
//    out_data/out_ts/out_lost are stable while out_valid=1 && out_ready=0.
//    out_data/out_ts/out_lost = 0 when empty.
//  Pointers wrap modulo DEPTH. count is the exact occupancy; no off-by-one at full.
//  clear=1: next edge count=0, ptrs=0, overflow=0, drop_cnt=0, lost_pending=0.
//    Same-cycle push/pop/drop are discarded; clear wins.
//  Reset asserted mid-transfer: immediate return to reset state; the entry being popped is lost.
// TESTING
//  1 reset release, a0_in 0->5 at cycle 3, ready=1 -> out_valid 1 cycle later, data=5, ts=3, lost=0
//  2 ready=0, 16 distinct changes, then a 17th -> count=16, overflow=1, drop_cnt=1;
//    drain: 16 entries in order; the next change after space frees carries out_lost=1
//  3 full FIFO, ready=1 plus a change in the same cycle -> count stays 16, drop_cnt stays 0
//  4 capture_en=0 while a0 toggles 1,2,3 -> count=0; enable, a0=4 -> one entry, data=4
//  5 8 entries, overflow=1, clear with a change and ready=1 the same cycle ->
//    count=0, overflow=0, drop_cnt=0, out_valid=0
//  6 TS_WIDTH=4, change at cycle 17 -> out_ts=1 (wrap); rst low mid-drain -> all outputs 0 at once

Source files
------------

// File: rtl/a0_trace_fifo.sv
// a0 change tracer: timestamps every change of the CPU a0 output into a FWFT FIFO
// drained over valid/ready, with sticky overflow and per-entry loss marking.
module a0_trace_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int TS_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    a0_in,
    input  logic                     capture_en,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [TS_WIDTH-1:0]      out_ts,
    output logic                     out_lost,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   L_FULL    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] L_PTR_ONE = AW'(1);
    localparam logic [AW:0]   L_CNT_ONE = (AW+1)'(1);

    logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
    logic [TS_WIDTH-1:0]   r_mem_ts   [DEPTH];
    logic                  r_mem_lost [DEPTH];

    logic [AW-1:0]         r_rd_ptr;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW:0]           r_count;
    logic                  r_overflow;
    logic [7:0]            r_drop_cnt;
    logic                  r_lost_pending;
    logic [TS_WIDTH-1:0]   r_ts;
    logic [DATA_WIDTH-1:0] r_a0_prev;

    logic w_change;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_valid;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign w_valid  = (r_count != '0);
    assign w_change = capture_en && (a0_in != r_a0_prev);
    assign w_pop    = w_valid && out_ready;
    // A full FIFO still accepts a change when the head leaves in the same cycle.
    assign w_push   = w_change && ((r_count != L_FULL) || w_pop);
    assign w_drop   = w_change && !w_push;

    // Storage carries data only; occupancy decides what is visible, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_push && !clear) begin
            r_mem_data[r_wr_ptr] <= a0_in;
            r_mem_ts[r_wr_ptr]   <= r_ts;
            r_mem_lost[r_wr_ptr] <= r_lost_pending;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr       <= '0;
            r_wr_ptr       <= '0;
            r_count        <= '0;
            r_overflow     <= 1'b0;
            r_drop_cnt     <= 8'd0;
            r_lost_pending <= 1'b0;
            r_ts           <= '0;
            r_a0_prev      <= '0;
        end else begin
            r_ts      <= r_ts + TS_WIDTH'(1);
            r_a0_prev <= a0_in;
            if (clear) begin
                r_rd_ptr       <= '0;
                r_wr_ptr       <= '0;
                r_count        <= '0;
                r_overflow     <= 1'b0;
                r_drop_cnt     <= 8'd0;
                r_lost_pending <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr       <= r_wr_ptr + L_PTR_ONE;
                    r_lost_pending <= 1'b0;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + L_CNT_ONE;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - L_CNT_ONE;
                end
                if (w_drop) begin
                    r_lost_pending <= 1'b1;
                    r_overflow     <= 1'b1;
                    r_drop_cnt     <= sat_inc8(r_drop_cnt);
                end
            end
        end
    end

    assign out_valid = w_valid;
    assign out_data  = w_valid ? r_mem_data[r_rd_ptr] : '0;
    assign out_ts    = w_valid ? r_mem_ts[r_rd_ptr]   : '0;
    assign out_lost  = w_valid ? r_mem_lost[r_rd_ptr] : 1'b0;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule
